// File: rtl/tone_mapping_pkg.sv
// Shared types and constants for the inverse tone mapping block.
package tone_mapping_pkg;
  localparam int ITM_W_DEFAULT = 10;
  localparam int ITM_LATENCY   = 3;

  typedef enum logic {IDLE, ACTIVE} itm_state_e;
endpackage

// File: rtl/itm_mult_add.sv
// Two registered stages: scale compressed pixel by diff and shift, then add min.
// Build option ITM_ROUND_EN rounds half-up before the shift instead of truncating.
module itm_mult_add
  import tone_mapping_pkg::*;
#(
  parameter int W = ITM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en1,
  input  logic         en2,
  input  logic [W-3:0] data,
  input  logic [W-1:0] min,
  input  logic [W-1:0] diff,
  output logic [W-1:0] result
);
  localparam int PW = 2*W-2;

  logic [PW-1:0] prod;
  logic [W-1:0]  scaled, min_q, diff_q, frac;

`ifdef ITM_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1) << (W-3);
  assign prod = PW'(data) * PW'(diff) + RND;
`else
  assign prod = PW'(data) * PW'(diff);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scaled <= '0;
      min_q  <= '0;
      diff_q <= '0;
    end else if (en1) begin
      scaled <= W'(prod >> (W-2));
      min_q  <= min;
      diff_q <= diff;
    end
  end

  // Rounding can land exactly on diff, never above; the clamp keeps min+frac within max.
  assign frac = (scaled > diff_q) ? diff_q : scaled;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  result <= '0;
    else if (en2)  result <= min_q + frac;
  end
endmodule

// File: rtl/inverse_tone_mapping.sv
// Expands W-2 bit pixels back to [min,max] with a 3-cycle pipeline, frame FSM and sticky error.
// Build option ITM_ROUND_EN selects round-half-up scaling in itm_mult_add.
module inverse_tone_mapping
  import tone_mapping_pkg::*;
#(
  parameter int W = ITM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] param_min,
  input  logic [W-1:0] param_max,
  input  logic         param_load,
  input  logic         sop,
  input  logic         eop,
  input  logic         valid,
  input  logic [W-3:0] data,
  output logic [W-1:0] data_o,
  output logic         sop_o,
  output logic         eop_o,
  output logic         valid_o,
  output logic         frame_err
);
  itm_state_e state, state_nxt;
  logic         err_nxt, sop_acc, pix_acc;
  logic [W-1:0] sh_min, sh_max, act_min, act_diff;
  logic [W-1:0] ld_min, ld_max, new_diff, pix_min, pix_diff;
  logic [W-1:0] min1, diff1;
  logic [W-3:0] data1;
  logic [ITM_LATENCY:0] vld_pipe, sop_pipe, eop_pipe;
  logic [ITM_LATENCY:1] vld_q, sop_q, eop_q;

  // A load in the same cycle as sop must reach that frame, so bypass the shadow.
  assign ld_min   = param_load ? param_min : sh_min;
  assign ld_max   = param_load ? param_max : sh_max;
  assign new_diff = (ld_max >= ld_min) ? ld_max - ld_min : '0;

  assign sop_acc  = valid & sop;
  assign pix_acc  = valid & (sop | (state == ACTIVE));
  assign pix_min  = sop_acc ? ld_min   : act_min;
  assign pix_diff = sop_acc ? new_diff : act_diff;

  assign vld_pipe = {vld_q, pix_acc};
  assign sop_pipe = {sop_q, sop_acc};
  assign eop_pipe = {eop_q, pix_acc & eop};

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: if (valid) begin
        if (sop) begin
          if (!eop) state_nxt = ACTIVE;
        end else begin
          err_nxt = 1'b1;
        end
      end
      ACTIVE: if (valid) begin
        if (sop) err_nxt   = 1'b1;
        if (eop) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= frame_err | err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_min   <= '0;
      sh_max   <= '1;
      act_min  <= '0;
      act_diff <= '1;
    end else begin
      sh_min <= ld_min;
      sh_max <= ld_max;
      if (sop_acc) begin
        act_min  <= ld_min;
        act_diff <= new_diff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
      data1 <= '0;
      min1  <= '0;
      diff1 <= '0;
    end else begin
      vld_q <= vld_pipe[ITM_LATENCY-1:0];
      sop_q <= sop_pipe[ITM_LATENCY-1:0];
      eop_q <= eop_pipe[ITM_LATENCY-1:0];
      if (vld_pipe[0]) begin
        data1 <= data;
        min1  <= pix_min;
        diff1 <= pix_diff;
      end
    end
  end

  assign valid_o = vld_q[ITM_LATENCY];
  assign sop_o   = sop_q[ITM_LATENCY];
  assign eop_o   = eop_q[ITM_LATENCY];

  itm_mult_add #(.W(W)) u_mult_add (
    .clk     (clk),
    .reset_n (reset_n),
    .en1     (vld_q[1]),
    .en2     (vld_q[2]),
    .data    (data1),
    .min     (min1),
    .diff    (diff1),
    .result  (data_o)
  );
endmodule

// File: tb/tb_inverse_tone_mapping.sv
// Self-checking bench: directed table, hand-written corner sequences, random traffic vs a frame-level model.
module tb_inverse_tone_mapping;
  localparam int W    = 10;
  localparam int DW   = W-2;
  localparam int FULL = (1 << W) - 1;
`ifdef ITM_ROUND_EN
  localparam int RND    = 1 << (W-3);
  localparam int EXP255 = 897;
`else
  localparam int RND    = 0;
  localparam int EXP255 = 896;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  param_min = '0, param_max = '0;
  logic          param_load = 1'b0, sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [W-1:0]  data_o;
  logic          sop_o, eop_o, valid_o, frame_err;

  inverse_tone_mapping #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .param_min(param_min), .param_max(param_max),
    .param_load(param_load), .sop(sop), .eop(eop), .valid(valid), .data(data),
    .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct {bit v; bit s; bit e; int d;} pix_t;
  pix_t q[$];
  int sh_min, sh_max, a_min, a_max, last_d;
  bit in_frame, m_err;

  typedef struct {
    bit pl; int pmn; int pmx; bit s; bit e; bit v; int d;
    bit ev; bit es; bit ee; int ed;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int expand(input int mn, input int mx, input int d);
    int df;
    df = (mx >= mn) ? mx - mn : 0;
    return mn + (d * df + RND) / (1 << DW);
  endfunction

  task automatic model_reset();
    q.delete();
    sh_min = 0; sh_max = FULL; a_min = 0; a_max = FULL;
    in_frame = 0; m_err = 0; last_d = 0;
  endtask

  // One clock: drive inputs, advance the model, compare every output after the edge.
  task automatic cycle(input bit pl, input int pmn, input int pmx,
                       input bit s, input bit e, input bit v, input int d);
    pix_t p, o;
    bit acc;
    param_load = pl; param_min = W'(pmn); param_max = W'(pmx);
    sop = s; eop = e; valid = v; data = DW'(d);
    if (pl) begin sh_min = pmn; sh_max = pmx; end
    acc = v && (s || in_frame);
    if (v && s && in_frame)   m_err = 1;
    if (v && !s && !in_frame) m_err = 1;
    if (acc && s) begin a_min = sh_min; a_max = sh_max; end
    p.v = acc; p.s = acc && s; p.e = acc && e;
    p.d = acc ? expand(a_min, a_max, d) : 0;
    if (v) begin
      if (s)      in_frame = !e;
      else if (e) in_frame = 0;
    end
    q.push_back(p);
    @(posedge clk); #1;
    o = '{0, 0, 0, 0};
    if (q.size() >= 3) o = q.pop_front();
    if (o.v) last_d = o.d;
    chk("valid_o", int'(valid_o), int'(o.v));
    chk("sop_o", int'(sop_o), int'(o.s));
    chk("eop_o", int'(eop_o), int'(o.e));
    chk("data_o", int'(data_o), last_d);
    chk("frame_err", int'(frame_err), int'(m_err));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_o"}, int'(data_o), 0);
    chk({tag, "_valid_o"}, int'(valid_o), 0);
    chk({tag, "_sop_o"}, int'(sop_o), 0);
    chk({tag, "_eop_o"}, int'(eop_o), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Asserted between edges so the asynchronous clear is observable at once.
  task automatic do_reset();
    reset_n = 1'b0;
    param_load = 0; sop = 0; eop = 0; valid = 0;
    #1;
    model_reset();
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1, 100, 900, 0, 0, 0, 0,   0, 0, 0, 0};
    tbl[1] = '{0, 0, 0,     1, 0, 1, 0,   0, 0, 0, 0};
    tbl[2] = '{0, 0, 0,     0, 0, 1, 128, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0,     0, 1, 1, 255, 1, 1, 0, 100};
    tbl[4] = '{0, 0, 0,     0, 0, 0, 0,   1, 0, 0, 500};
    tbl[5] = '{0, 0, 0,     0, 0, 0, 0,   1, 0, 1, EXP255};
    tbl[6] = '{0, 0, 0,     0, 0, 0, 0,   0, 0, 0, EXP255};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // Basic expansion with min=100, max=900
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].pl, tbl[i].pmn, tbl[i].pmx, tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), int'(valid_o), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_sop", i), int'(sop_o), int'(tbl[i].es));
      chk($sformatf("tbl%0d_eop", i), int'(eop_o), int'(tbl[i].ee));
      chk($sformatf("tbl%0d_data", i), int'(data_o), tbl[i].ed);
    end

    // Mid-frame load leaves the running frame alone
    cycle(0, 0, 0,    1, 0, 1, 255);
    cycle(1, 0, 1023, 0, 0, 1, 255);
    cycle(0, 0, 0,    0, 1, 1, 255);
    chk("midload_old0", int'(data_o), EXP255);
    idle();
    chk("midload_old1", int'(data_o), EXP255);
    idle();
    chk("midload_old2", int'(data_o), EXP255);
    chk("midload_eop", int'(eop_o), 1);
    // Single-pixel frame picks up the new parameters
    cycle(0, 0, 0, 1, 1, 1, 255);
    idle(); idle();
    chk("single_valid", int'(valid_o), 1);
    chk("single_sop", int'(sop_o), 1);
    chk("single_eop", int'(eop_o), 1);
    chk("single_1019", int'(data_o), 1019);

    // max < min collapses to min
    cycle(1, 500, 400, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) cycle(0, 0, 0, i == 0, i == 4, 1, int'($urandom_range(0, 255)));
      else       idle();
      if (valid_o) begin
        n++;
        chk("diff0_data", int'(data_o), 500);
      end
    end
    chk("diff0_count", n, 5);

    // sop inside a frame: error, pixel restarts the frame
    cycle(1, 100, 900, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 10);
    cycle(0, 0, 0, 0, 0, 1, 20);
    chk("pre_err_clear", int'(frame_err), 0);
    cycle(0, 0, 0, 1, 0, 1, 32);
    chk("sop_active_err", int'(frame_err), 1);
    cycle(0, 0, 0, 0, 1, 1, 40);
    idle();
    chk("sop_active_valid", int'(valid_o), 1);
    chk("sop_active_sop", int'(sop_o), 1);
    chk("sop_active_data", int'(data_o), 200);
    idle(); idle();

    // Reset mid-frame with a full pipeline
    cycle(0, 0, 0, 1, 0, 1, 64);
    cycle(0, 0, 0, 0, 0, 1, 64);
    cycle(0, 0, 0, 0, 0, 1, 64);
    do_reset();
    cycle(0, 0, 0, 0, 0, 1, 100);
    chk("idle_valid_err", int'(frame_err), 1);
    idle(); idle();
    chk("idle_valid_dropped", int'(valid_o), 0);
    cycle(0, 0, 0, 1, 1, 1, 255);
    cycle(0, 0, 0, 0, 0, 1, 200);
    idle();
    chk("rst_params_valid", int'(valid_o), 1);
    chk("rst_params_1019", int'(data_o), 1019);
    idle();
    chk("single_stays_idle", int'(valid_o), 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 15) == 0,
            int'($urandom_range(0, FULL)), int'($urandom_range(0, FULL)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inverse_tone_mapping.md
INVERSE_TONE_MAPPING -- requirements
Module: inverse_tone_mapping

Interface
REQ-001 SHALL have parameter W, default 10, giving the expanded pixel width; the compressed pixel width is W-2.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port param_min, input, W, the frame minimum to restore.
REQ-005 SHALL have port param_max, input, W, the frame maximum to restore.
REQ-006 SHALL have port param_load, input, 1, a one-cycle strobe that captures param_min/param_max.
REQ-007 SHALL have ports sop, eop and valid, input, 1 each: input frame start, frame end and pixel qualifier.
REQ-008 SHALL have port data, input, W-2, the compressed pixel.
REQ-009 SHALL have port data_o, output, W, the expanded pixel.
REQ-010 SHALL have ports sop_o, eop_o and valid_o, output, 1 each: output markers aligned with data_o.
REQ-011 SHALL have port frame_err, output, 1, a sticky protocol error flag.

Function
REQ-012 SHALL capture param_min/param_max into shadow registers on param_load, independent of frame state.
REQ-013 SHALL copy the shadow registers to the active registers on each accepted sop (sop&valid); param_load coincident with that sop SHALL apply to that frame.
REQ-014 SHALL compute diff = active_max - active_min at shadow-to-active transfer; diff SHALL be 0 when max<min.
REQ-015 SHALL compute data_o = active_min + ((data * diff) >> (W-2)); the product is 2W-2 bits wide and the result SHALL NOT exceed active_max.
REQ-016 SHALL be fully pipelined, accepting one pixel per cycle, with a fixed latency of 3 cycles from valid to valid_o.
REQ-017 SHALL delay sop, eop and valid through the same 3 stages, so that sop_o/eop_o are asserted only together with valid_o.
REQ-018 SHALL implement a 2-state FSM: IDLE goes to ACTIVE on sop&valid; ACTIVE goes to IDLE on eop&valid; sop&eop&valid in IDLE is a one-pixel frame and the FSM SHALL stay in IDLE.
REQ-019 SHALL set frame_err when it sees sop&valid in ACTIVE; that pixel SHALL still be processed as a new frame start with the parameter transfer.
REQ-020 SHALL set frame_err for valid without sop in IDLE; that pixel SHALL be dropped, with no valid_o.
REQ-021 SHALL set frame_err for eop&valid in IDLE without sop.
REQ-022 SHALL ignore sop/eop while valid=0.
REQ-023 SHALL hold frame_err until reset.
REQ-024 SHALL hold data_o at its last value when valid_o=0.

Reset
REQ-025 SHALL, on reset_n low: clear data_o, sop_o, eop_o, valid_o, frame_err and all pipeline valids to 0, and put the FSM in IDLE.
REQ-026 SHALL, on reset_n low: set the shadow and active registers to min=0 and max=2^W-1.
REQ-027 SHALL discard in-flight pixels when reset occurs mid-frame, with no valid_o after release until a new sop.

Configuration
REQ-028 SHALL, with ITM_ROUND_EN defined, add 2^(W-3) to the product before the shift (round-half-up); without it, truncate.
REQ-029 SHALL keep latency and the output bound of REQ-015 identical in both builds.

Structure
REQ-030 SHALL take from package tone_mapping_pkg: the FSM state typedef (IDLE, ACTIVE), the latency constant ITM_LATENCY=3 and the default width constant.
REQ-031 SHALL place the registered 2-stage multiply-add (product, shift, add min) in sub-module itm_mult_add; the top level holds the FSM, parameter registers and marker delay line.

Verification
REQ-032 SHALL be verified with: load min=100, max=900, frame data 0,128,255 -> data_o 100,500,896 (ITM_ROUND_EN: 100,500,897), each 3 cycles after its input.
REQ-033 SHALL be verified with: param_load min=0, max=1023 mid-frame -> current frame keeps the old values; next sop applies the new values; data=255 -> 1019.
REQ-034 SHALL be verified with: min=500, max=400 -> diff 0, every data_o=500.
REQ-035 SHALL be verified with: sop while ACTIVE -> frame_err=1 and the pixel is output with sop_o; valid while IDLE -> frame_err=1 and no valid_o.
REQ-036 SHALL be verified with: reset_n pulsed low mid-frame -> all outputs 0 immediately, no valid_o until the next sop, parameters back to 0/1023.
REQ-037 SHALL be verified with: sop&eop&valid single pixel -> sop_o=eop_o=valid_o=1 in the same cycle, FSM stays IDLE.
